// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encoding, opcodes and datapath select encodings
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    EXC     = 4'd12
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - counts consecutive memack-less request cycles
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (waiting) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires in the TIMEOUT-th consecutive wait cycle, so the access spans exactly TIMEOUT cycles.
  assign expired = waiting && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS controller FSM with memory handshake timeout
// Define MCCTRL_LB_EN to decode the LB opcode; otherwise it traps to EXC.
module mips_mc_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memack,
  output logic       memreq,
  output logic       iord,
  output logic       memwrite,
  output logic       membyteread,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       exception,
  output logic       retire,
  output logic [3:0] state
);

  import mc_pkg::*;

  statetype_t r_state;
  statetype_t w_next;
  logic       w_waiting;
  logic       w_clear;
  logic       w_expired;
  logic       w_byte;

`ifdef MCCTRL_LB_EN
  assign w_byte = (op == OP_LB);
`else
  assign w_byte = 1'b0;
`endif

  assign w_waiting = ((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR)) && !memack;
  assign w_clear   = (w_next != r_state);
  assign state     = r_state;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .waiting (w_waiting),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: begin
        if (memack)         w_next = DECODE;
        else if (w_expired) w_next = EXC;
      end
      DECODE: begin
        case (op)
          OP_RTYPE:     w_next = RTYPEEX;
          OP_LW, OP_SW: w_next = MEMADR;
`ifdef MCCTRL_LB_EN
          OP_LB:        w_next = MEMADR;
`endif
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default:      w_next = EXC;
        endcase
      end
      MEMADR: w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (memack)         w_next = MEMWB;
        else if (w_expired) w_next = EXC;
      end
      MEMWR: begin
        if (memack)         w_next = FETCH;
        else if (w_expired) w_next = EXC;
      end
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX, EXC: w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  // Moore outputs, except the memack-qualified strobes of the request states.
  always_comb begin
    memreq      = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    membyteread = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    pcsrc       = PCSRC_ALURES;
    aluop       = ALUOP_ADD;
    exception   = 1'b0;
    retire      = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          memreq  = 1'b1;
          alusrcb = SRCB_FOUR;
          irwrite = memack;
          pcwrite = memack;
        end
        DECODE: alusrcb = SRCB_IMMSH;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        MEMRD: begin
          memreq      = 1'b1;
          iord        = 1'b1;
          membyteread = w_byte;
        end
        MEMWB: begin
          regwrite    = 1'b1;
          memtoreg    = 1'b1;
          membyteread = w_byte;
          retire      = 1'b1;
        end
        MEMWR: begin
          memreq   = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
          retire   = memack;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          retire   = 1'b1;
        end
        BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          branch  = 1'b1;
          pcsrc   = PCSRC_ALUOUT;
          retire  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        ADDIWB: begin
          regwrite = 1'b1;
          retire   = 1'b1;
        end
        JEX: begin
          pcwrite = 1'b1;
          pcsrc   = PCSRC_JUMP;
          retire  = 1'b1;
        end
        EXC: begin
          exception = 1'b1;
          pcwrite   = 1'b1;
          pcsrc     = PCSRC_EXC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - randomized trace-model testbench for mips_mc_ctrl
module tb_mips_mc_ctrl;

  localparam int TO = 4;
`ifdef MCCTRL_LB_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
                         S_BEQEX = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX = 4'd11,
                         S_EXC = 4'd12;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memack;
  logic       memreq, iord, memwrite, membyteread, irwrite, pcwrite, branch;
  logic       regwrite, regdst, memtoreg, alusrca, exception, retire;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       ack;
  } cyc_t;
  cyc_t q[$];

  always #5 clk = ~clk;

  mips_mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .memack(memack),
    .memreq(memreq), .iord(iord), .memwrite(memwrite), .membyteread(membyteread),
    .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .exception(exception), .retire(retire), .state(state)
  );

  wire [18:0] w_obs = {memreq, iord, memwrite, membyteread, irwrite, pcwrite, branch,
                       regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
                       exception, retire};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (op=%b t=%0t)", tag, obs, exp, op, $time);
    end
  endtask

  // Expected outputs straight from the per-state output table.
  function automatic logic [18:0] exp_out(input logic [3:0] st, input logic ack, input logic [5:0] o);
    logic mreq, ird, mw, mbr, irw, pcw, br, rw, rd, m2r, sa, ex, ret;
    logic [1:0] sb, ps, ao;
    logic lbop;
    {mreq, ird, mw, mbr, irw, pcw, br, rw, rd, m2r, sa, ex, ret} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    lbop = LB_EN && (o == 6'b100000);
    case (st)
      S_FETCH:   begin mreq = 1; sb = 2'b01; irw = ack; pcw = ack; end
      S_DECODE:  sb = 2'b11;
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   begin mreq = 1; ird = 1; mbr = lbop; end
      S_MEMWB:   begin rw = 1; m2r = 1; mbr = lbop; ret = 1; end
      S_MEMWR:   begin mreq = 1; ird = 1; mw = 1; ret = ack; end
      S_RTYPEEX: begin sa = 1; ao = 2'b10; end
      S_RTYPEWB: begin rd = 1; rw = 1; ret = 1; end
      S_BEQEX:   begin sa = 1; ao = 2'b01; br = 1; ps = 2'b01; ret = 1; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_ADDIWB:  begin rw = 1; ret = 1; end
      S_JEX:     begin pcw = 1; ps = 2'b10; ret = 1; end
      S_EXC:     begin ex = 1; pcw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {mreq, ird, mw, mbr, irw, pcw, br, rw, rd, m2r, sa, sb, ps, ao, ex, ret};
  endfunction

  // One memory access of w wait cycles; w >= TO means the access times out into EXC.
  task automatic add_access(input logic [3:0] st, input int w, output bit tmo);
    tmo = 1'b0;
    if (w >= TO) begin
      for (int i = 0; i < TO; i++) q.push_back({st, 1'b0});
      q.push_back({S_EXC, 1'($urandom_range(0, 1))});
      tmo = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) q.push_back({st, 1'b0});
      q.push_back({st, 1'b1});
    end
  endtask

  function automatic void push_idle(input logic [3:0] st);
    q.push_back({st, 1'($urandom_range(0, 1))});
  endfunction

  task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
    bit tmo;
    q.delete();
    op = o;
    add_access(S_FETCH, wf, tmo);
    if (!tmo) begin
      push_idle(S_DECODE);
      if (o == 6'b000000) begin
        push_idle(S_RTYPEEX); push_idle(S_RTYPEWB);
      end else if (o == 6'b100011 || (LB_EN && o == 6'b100000)) begin
        push_idle(S_MEMADR);
        add_access(S_MEMRD, wm, tmo);
        if (!tmo) push_idle(S_MEMWB);
      end else if (o == 6'b101011) begin
        push_idle(S_MEMADR);
        add_access(S_MEMWR, wm, tmo);
      end else if (o == 6'b000100) begin
        push_idle(S_BEQEX);
      end else if (o == 6'b001000) begin
        push_idle(S_ADDIEX); push_idle(S_ADDIWB);
      end else if (o == 6'b000010) begin
        push_idle(S_JEX);
      end else begin
        push_idle(S_EXC);
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      memack = q[i].ack;
      @(negedge clk);
      check_eq($sformatf("state[%0d]", i), 32'(state), 32'(q[i].st));
      check_eq($sformatf("outs[%0d]", i), 32'(w_obs), 32'(exp_out(q[i].st, q[i].ack, o)));
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_tbl[9];

  initial begin
    op_tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b100000, 6'b000100,
               6'b001000, 6'b000010, 6'b111111, 6'b000000};
    reset = 1'b1; op = 6'b000000; memack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", 32'(w_obs), 32'd0);
    check_eq("reset_state", 32'(state), 32'(S_FETCH));
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b001000, TO, 0);
    run_instr(6'b101011, TO - 1, TO - 1);
    run_instr(6'b100011, 1, TO);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b100000, 0, 1);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 2, 0);

    // Reset during a store wait: strobes drop, no retire, fresh FETCH.
    op = 6'b101011; memack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memack = 1'b0;
    @(negedge clk);
    check_eq("mid_wr_state", 32'(state), 32'(S_MEMWR));
    @(posedge clk); #1;
    reset = 1'b1; memack = 1'b1;
    @(negedge clk);
    check_eq("mid_wr_rst_outs", 32'(w_obs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(6'b001000, TO, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 9) == 9) ? 6'($urandom) : op_tbl[$urandom_range(0, 8)];
      run_instr(o, $urandom_range(0, TO + 1), $urandom_range(0, TO + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
